// File: rtl/cp_host_loader_if.sv
// Bundle of host, result and memory-side signals for cp_host_loader.
// "master" is the host/environment side, "slave" is the loader itself.
interface cp_host_loader_if #(
    parameter int CP_D_WIDTH      = 72,
    parameter int CP_I_WIDTH      = 56,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int IMEM_ADDR_WIDTH = 9
);
    // job request
    logic                       start;
    logic [IMEM_ADDR_WIDTH:0]   imem_len;
    logic [DMEM_ADDR_WIDTH:0]   dmem_len;
    logic [DMEM_ADDR_WIDTH-1:0] res_base;
    logic [DMEM_ADDR_WIDTH:0]   res_len;
    // host input stream
    logic                       in_valid;
    logic                       in_ready;
    logic [CP_D_WIDTH-1:0]      in_data;
    // result stream
    logic                       out_valid;
    logic                       out_ready;
    logic [CP_D_WIDTH-1:0]      out_data;
    // status
    logic                       busy;
    logic                       job_done;
    // coprocessor hand-off
    logic                       ext_cp_active;
    logic                       cp_ext_done;
    // memory ports
    logic [IMEM_ADDR_WIDTH-1:0] ext_imem_addr;
    logic [CP_I_WIDTH-1:0]      ext_imem_in;
    logic                       ext_imem_we;
    logic [DMEM_ADDR_WIDTH-1:0] ext_dmem_addr;
    logic [CP_D_WIDTH-1:0]      ext_dmem_in;
    logic                       ext_dmem_we;
    logic [CP_D_WIDTH-1:0]      dmem_ext_out;

    modport master (
        output start, imem_len, dmem_len, res_base, res_len,
        output in_valid, in_data, out_ready, cp_ext_done, dmem_ext_out,
        input  in_ready, out_valid, out_data, busy, job_done, ext_cp_active,
        input  ext_imem_addr, ext_imem_in, ext_imem_we,
        input  ext_dmem_addr, ext_dmem_in, ext_dmem_we
    );

    modport slave (
        input  start, imem_len, dmem_len, res_base, res_len,
        input  in_valid, in_data, out_ready, cp_ext_done, dmem_ext_out,
        output in_ready, out_valid, out_data, busy, job_done, ext_cp_active,
        output ext_imem_addr, ext_imem_in, ext_imem_we,
        output ext_dmem_addr, ext_dmem_in, ext_dmem_we
    );
endinterface

// File: rtl/cp_host_loader.sv
// Host-side job sequencer for the coprocessor: streams instruction and
// operand words into IMEM/DMEM, hands DMEM port C to the coprocessor while
// it runs, then reads a result window back out through a valid/ready port.
module cp_host_loader #(
    parameter int CP_D_WIDTH      = 72,
    parameter int CP_I_WIDTH      = 56,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int IMEM_ADDR_WIDTH = 9
) (
    input logic              clock,
    input logic              reset,
    cp_host_loader_if.slave  bus
);
    localparam int IW = IMEM_ADDR_WIDTH;
    localparam int DW = DMEM_ADDR_WIDTH;
    localparam logic [IW:0] I_ONE = 1;
    localparam logic [DW:0] D_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_FIN
    } state_t;

    state_t state_q, state_d;

    // latched job parameters
    logic [IW:0]   imem_len_q;
    logic [DW:0]   dmem_len_q;
    logic [DW:0]   res_len_q;
    logic [DW-1:0] res_base_q;

    // counters are one bit wider than the address so a full-depth length terminates
    logic [IW:0]   icnt_q, icnt_d;
    logic [DW:0]   dcnt_q, dcnt_d;
    logic [DW:0]   ridx_q, ridx_d;

    logic [CP_D_WIDTH-1:0] out_data_q, out_data_d;

    // readback address wraps naturally at the DMEM address width
    logic [DW-1:0] rd_addr;
    assign rd_addr = res_base_q + ridx_q[DW-1:0];

    assign bus.out_data = out_data_q;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // counters, captured result and job parameters (latched on an accepted start)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icnt_q     <= '0;
            dcnt_q     <= '0;
            ridx_q     <= '0;
            out_data_q <= '0;
            imem_len_q <= '0;
            dmem_len_q <= '0;
            res_len_q  <= '0;
            res_base_q <= '0;
        end else begin
            icnt_q     <= icnt_d;
            dcnt_q     <= dcnt_d;
            ridx_q     <= ridx_d;
            out_data_q <= out_data_d;
            if (state_q == S_IDLE && bus.start) begin
                imem_len_q <= bus.imem_len;
                dmem_len_q <= bus.dmem_len;
                res_len_q  <= bus.res_len;
                res_base_q <= bus.res_base;
            end
        end
    end

    // next-state and counter updates
    always_comb begin
        state_d    = state_q;
        icnt_d     = icnt_q;
        dcnt_d     = dcnt_q;
        ridx_d     = ridx_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    icnt_d = '0;
                    dcnt_d = '0;
                    ridx_d = '0;
                    if (bus.imem_len != '0) begin
                        state_d = S_LOAD_I;
                    end else if (bus.dmem_len != '0) begin
                        state_d = S_LOAD_D;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_LOAD_I: begin
                if (bus.in_valid) begin
                    icnt_d = icnt_q + I_ONE;
                    if (icnt_d == imem_len_q) begin
                        state_d = (dmem_len_q != '0) ? S_LOAD_D : S_RUN;
                    end
                end
            end
            S_LOAD_D: begin
                if (bus.in_valid) begin
                    dcnt_d = dcnt_q + D_ONE;
                    if (dcnt_d == dmem_len_q) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.cp_ext_done) begin
                    state_d = (res_len_q != '0) ? S_RD_ADDR : S_FIN;
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                out_data_d = bus.dmem_ext_out;
                state_d    = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (bus.out_ready) begin
                    if (ridx_q + D_ONE == res_len_q) begin
                        state_d = S_FIN;
                    end else begin
                        ridx_d  = ridx_q + D_ONE;
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore/Mealy outputs; IDLE drives everything low, which also covers reset
    always_comb begin
        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.busy          = (state_q != S_IDLE);
        bus.job_done      = 1'b0;
        bus.ext_cp_active = 1'b0;
        bus.ext_imem_addr = '0;
        bus.ext_imem_in   = '0;
        bus.ext_imem_we   = 1'b0;
        bus.ext_dmem_addr = '0;
        bus.ext_dmem_in   = '0;
        bus.ext_dmem_we   = 1'b0;
        case (state_q)
            S_LOAD_I: begin
                bus.in_ready      = 1'b1;
                bus.ext_imem_we   = bus.in_valid;
                bus.ext_imem_addr = icnt_q[IW-1:0];
                bus.ext_imem_in   = bus.in_data[CP_I_WIDTH-1:0];
            end
            S_LOAD_D: begin
                bus.in_ready      = 1'b1;
                bus.ext_dmem_we   = bus.in_valid;
                bus.ext_dmem_addr = dcnt_q[DW-1:0];
                bus.ext_dmem_in   = bus.in_data;
            end
            S_RUN: begin
                bus.ext_cp_active = 1'b1;
            end
            // the read address is held through the wait and output phases
            S_RD_ADDR, S_RD_WAIT: begin
                bus.ext_dmem_addr = rd_addr;
            end
            S_RD_OUT: begin
                bus.ext_dmem_addr = rd_addr;
                bus.out_valid     = 1'b1;
            end
            S_FIN: begin
                bus.job_done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_cp_host_loader.sv
// Directed bench for cp_host_loader with an IMEM/DMEM stub, a coprocessor
// stub and a queue-based model of the writes and readback a job must produce.
module tb_cp_host_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;

    cp_host_loader_if bus ();

    cp_host_loader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          addr;
        logic [71:0] data;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;

    wr_t         exp_i[$];
    wr_t         exp_d[$];
    logic [71:0] exp_r[$];
    logic [71:0] got_res[$];
    logic [71:0] gold [0:1023];

    int wr_i_cnt = 0;
    int wr_d_cnt = 0;
    int done_cnt = 0;
    int rdy_cnt  = 0;
    int cp_delay = 10;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event with no expectation / bound expired", nm);
    endtask

    // memory stub: synchronous writes, one-cycle registered read on port C
    logic [71:0] dmem_mem [0:1023];
    initial begin
        for (int a = 0; a < 1024; a++) dmem_mem[a] = {32'hDEADBEEF, 40'(a)};
        bus.dmem_ext_out = '0;
        forever begin
            @(posedge clock);
            if (bus.ext_dmem_we) dmem_mem[bus.ext_dmem_addr] <= bus.ext_dmem_in;
            bus.dmem_ext_out <= dmem_mem[bus.ext_dmem_addr];
        end
    end

    // coprocessor stub: raises cp_ext_done in the cp_delay-th cycle of RUN
    initial begin
        int cnt;
        cnt = 0;
        bus.cp_ext_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || !bus.ext_cp_active) begin
                cnt = 0;
                bus.cp_ext_done = 1'b0;
            end else begin
                cnt++;
                bus.cp_ext_done = (cnt == cp_delay);
            end
        end
    end

    // per-cycle compare process against the model queues and handshake rules
    initial begin
        bit          have_prev;
        bit          p_ov, p_or, p_cp, p_done, p_jd;
        logic [71:0] p_data;
        logic [9:0]  p_addr;
        wr_t         e;
        have_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                have_prev = 1'b0;
                continue;
            end
            if (!bus.busy)
                chk("idle_quiet", {bus.in_ready, bus.ext_imem_we, bus.ext_dmem_we, bus.out_valid,
                                   bus.ext_cp_active, bus.job_done, bus.ext_imem_addr, bus.ext_dmem_addr}, 0);
            if (bus.ext_cp_active)
                chk("run_exclusive", {bus.in_ready, bus.ext_imem_we, bus.ext_dmem_we, bus.out_valid, bus.busy}, 5'b00001);
            if (bus.ext_imem_we) begin
                wr_i_cnt++;
                chk("imem_we_handshake", {bus.in_valid, bus.in_ready}, 2'b11);
                if (exp_i.size() == 0) fail_now("imem_unexpected_write");
                else begin
                    e = exp_i.pop_front();
                    chk("imem_addr", bus.ext_imem_addr, e.addr);
                    chk("imem_data", bus.ext_imem_in, e.data);
                end
            end
            if (bus.ext_dmem_we) begin
                wr_d_cnt++;
                chk("dmem_we_handshake", {bus.in_valid, bus.in_ready}, 2'b11);
                if (exp_d.size() == 0) fail_now("dmem_unexpected_write");
                else begin
                    e = exp_d.pop_front();
                    chk("dmem_addr", bus.ext_dmem_addr, e.addr);
                    chk("dmem_data", bus.ext_dmem_in, e.data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got_res.push_back(bus.out_data);
                if (exp_r.size() == 0) fail_now("result_unexpected");
                else chk("result_data", bus.out_data, exp_r.pop_front());
            end
            if (have_prev && p_ov && !p_or)
                chk("backpressure_hold", {bus.out_valid, bus.out_data, bus.ext_dmem_addr}, {1'b1, p_data, p_addr});
            if (have_prev && p_cp && p_done)
                chk("cp_active_drop", bus.ext_cp_active, 0);
            if (have_prev && p_jd)
                chk("job_done_one_cycle", bus.job_done, 0);
            if (bus.job_done) done_cnt++;
            if (bus.in_ready) rdy_cnt++;
            have_prev = 1'b1;
            p_ov   = bus.out_valid;
            p_or   = bus.out_ready;
            p_cp   = bus.ext_cp_active;
            p_done = bus.cp_ext_done;
            p_jd   = bus.job_done;
            p_data = bus.out_data;
            p_addr = bus.ext_dmem_addr;
        end
    end

    // One job: build expectations, drive start, feed words, drain results.
    task automatic run_job(input int ilen, input int dlen, input int base, input int rlen,
                           input int delay, input int bp, input bit rnd, input bit extra, input bit abort);
        logic [71:0] words[$];
        logic [71:0] w;
        int  idx, cyc, ov, d0, r0, wi0, wd0;
        bit  done_seen, fire, extra_done, prev_done_hs;
        idx = 0; cyc = 0; ov = 0;
        done_seen = 0; extra_done = 0; prev_done_hs = 0;
        for (int i = 0; i < ilen; i++) begin
            w = {8'($urandom), $urandom, $urandom};
            words.push_back(w);
            exp_i.push_back('{addr: i, data: {16'h0, w[55:0]}});
        end
        for (int j = 0; j < dlen; j++) begin
            w = {8'($urandom), $urandom, $urandom};
            words.push_back(w);
            exp_d.push_back('{addr: j, data: w});
            gold[j] = w;
        end
        for (int k = 0; k < rlen; k++) exp_r.push_back(gold[(base + k) % 1024]);
        cp_delay = delay;
        d0 = done_cnt; r0 = rdy_cnt; wi0 = wr_i_cnt; wd0 = wr_d_cnt;
        bus.imem_len  = 10'(ilen);
        bus.dmem_len  = 11'(dlen);
        bus.res_base  = 10'(base);
        bus.res_len   = 11'(rlen);
        bus.out_ready = (bp == 0);
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = (words.size() > 0);
        bus.in_data  = (words.size() > 0) ? words[0] : '0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (abort && bus.ext_cp_active) begin
                #2;
                reset = 1'b1;
                #1;
                chk("reset_async_run", {bus.ext_cp_active, bus.busy, bus.out_valid, bus.in_ready,
                                        bus.job_done, bus.out_data}, 0);
                @(posedge clock);
                #1;
                exp_i.delete(); exp_d.delete(); exp_r.delete();
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b0;
                reset = 1'b0;
                return;
            end
            if (cyc == 1 && ilen == 0 && dlen == 0) chk("zero_len_to_run", bus.ext_cp_active, 1);
            if (prev_done_hs && rlen == 0) chk("fin_after_cp_done", bus.job_done, 1);
            prev_done_hs = bus.ext_cp_active && bus.cp_ext_done;
            fire = bus.in_valid && bus.in_ready;
            if (bus.out_valid) ov++;
            if (bus.job_done) done_seen = 1;
            @(posedge clock);
            #1;
            if (fire) idx++;
            bus.in_valid = (idx < words.size()) && (!rnd || $urandom_range(0, 1) == 1);
            bus.in_data  = (idx < words.size()) ? words[idx] : '0;
            bus.start    = 1'b0;
            if (extra && !extra_done && idx > ilen && idx < words.size()) begin
                bus.start  = 1'b1;
                extra_done = 1;
            end
            bus.out_ready = (bp == 0) || (ov >= bp);
        end
        bus.start = 1'b0;
        if (!done_seen) fail_now("job_timeout");
        repeat (4) @(negedge clock);
        chk("busy_after_job", bus.busy, 0);
        chk("job_done_count", done_cnt - d0, 1);
        chk("imem_write_count", wr_i_cnt - wi0, ilen);
        chk("dmem_write_count", wr_d_cnt - wd0, dlen);
        chk("expectations_left", exp_i.size() + exp_d.size() + exp_r.size(), 0);
        if (ilen == 0 && dlen == 0) chk("zero_len_no_in_ready", rdy_cnt - r0, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int g0;
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        for (int a = 0; a < 1024; a++) gold[a] = {32'hDEADBEEF, 40'(a)};
        bus.start = 0; bus.imem_len = '0; bus.dmem_len = '0; bus.res_base = '0; bus.res_len = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {bus.in_ready, bus.out_valid, bus.busy, bus.job_done, bus.ext_cp_active,
                              bus.ext_imem_we, bus.ext_dmem_we, bus.ext_imem_addr, bus.ext_dmem_addr,
                              bus.out_data}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // basic job, start on the first edge after reset release
        g0 = got_res.size();
        run_job(3, 2, 5, 2, 10, 0, 0, 0, 0);
        chk("basic_res0_literal", got_res[g0],     72'hDEADBEEF0000000005);
        chk("basic_res1_literal", got_res[g0 + 1], 72'hDEADBEEF0000000006);

        // result backpressure over loaded operands
        run_job(2, 4, 1, 3, 5, 7, 0, 0, 0);

        // all lengths zero
        run_job(0, 0, 0, 0, 4, 0, 0, 0, 0);

        // readback address wrap
        g0 = got_res.size();
        run_job(1, 2, 1022, 4, 3, 0, 0, 0, 0);
        chk("wrap_res0_literal", got_res[g0],     72'hDEADBEEF00000003FE);
        chk("wrap_res1_literal", got_res[g0 + 1], 72'hDEADBEEF00000003FF);

        // reset while the coprocessor holds the port, then a normal job
        run_job(2, 2, 0, 1, 1000, 0, 0, 0, 1);
        run_job(1, 1, 0, 2, 2, 0, 0, 0, 0);

        // random in_valid stalls and a stray start during LOAD_D
        run_job(4, 6, 100, 2, 3, 0, 1, 1, 0);

        // full-depth loads
        run_job(512, 1024, 1020, 6, 2, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cp_host_loader.md
CP_HOST_LOADER -- requirements
Module: cp_host_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  CP_D_WIDTH  72  datapath word width
  CP_I_WIDTH  56  instruction word width
  DMEM_ADDR_WIDTH  10  DMEM address bits
  IMEM_ADDR_WIDTH  9  IMEM address bits
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  clock  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  start  in  1  one-cycle job request
  imem_len  in  IMEM_ADDR_WIDTH+1  instruction words to load
  dmem_len  in  DMEM_ADDR_WIDTH+1  operand words to load at DMEM 0
  res_base  in  DMEM_ADDR_WIDTH  first result address
  res_len  in  DMEM_ADDR_WIDTH+1  result words to read back
  in_valid / in_ready  in / out  1  host input handshake
  in_data  in  CP_D_WIDTH  host word; IMEM uses bits [CP_I_WIDTH-1:0]
  out_valid / out_ready  out / in  1  result output handshake
  out_data  out  CP_D_WIDTH  result word
  busy  out  1  job in progress
  job_done  out  1  one-cycle end-of-job pulse
  ext_cp_active  out  1  hands DMEM port C to the coprocessor
  cp_ext_done  in  1  coprocessor completion
  ext_imem_addr / ext_imem_in / ext_imem_we  out  IMEM_ADDR_WIDTH / CP_I_WIDTH / 1  IMEM write port
  ext_dmem_addr / ext_dmem_in / ext_dmem_we  out  DMEM_ADDR_WIDTH / CP_D_WIDTH / 1  DMEM port C
  dmem_ext_out  in  CP_D_WIDTH  DMEM port C read data

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD_I, LOAD_D, RUN, RD_ADDR, RD_WAIT, RD_OUT and FIN.
REQ-004 In IDLE, start=1 SHALL latch all length and base inputs and move to the first non-zero phase, in the order LOAD_I, LOAD_D, RUN; a start arriving outside IDLE SHALL be ignored.
REQ-005 Phases with zero length SHALL be skipped; RUN is always entered.
REQ-006 LOAD_I: in_ready=1. On each in_valid&in_ready, the block SHALL drive ext_imem_we=1 in the same cycle, with ext_imem_addr = a counter starting at 0. After imem_len words, it SHALL advance.
REQ-007 LOAD_D: same rule as LOAD_I, using ext_dmem_we, ext_dmem_addr counting from 0, and ext_dmem_in=in_data, for dmem_len words.
REQ-008 in_ready SHALL be 0 in every state other than LOAD_I and LOAD_D.
REQ-009 RUN: ext_cp_active=1 until cp_ext_done=1 is sampled; in that cycle ext_cp_active SHALL drop for the next cycle. The block SHALL then go to RD_ADDR if res_len>0, otherwise to FIN.
REQ-010 ext_cp_active SHALL be 1 only in RUN.
REQ-011 All write enables SHALL be 0 outside their load handshake cycle.
REQ-012 Readback (DMEM read latency is one cycle):
  RD_ADDR drives ext_dmem_addr = res_base + index, with wrap modulo 2^DMEM_ADDR_WIDTH.
  RD_WAIT captures dmem_ext_out into out_data.
  RD_OUT holds out_valid=1 and out_data stable until out_ready=1.
REQ-013 After the final acceptance in RD_OUT the block SHALL go to FIN; otherwise it SHALL increment the index and return to RD_ADDR.
REQ-014 FIN SHALL pulse job_done=1 for exactly one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Counters SHALL be IMEM_ADDR_WIDTH+1 / DMEM_ADDR_WIDTH+1 bits wide, so that a full-depth length (2^N) loads every address exactly once.
REQ-017 In any loading state, in_valid=0 SHALL stall the block with no write and no counter change.

Reset
REQ-018 Asserting reset at any time SHALL immediately force IDLE.
REQ-019 During reset, all outputs SHALL be 0, including ext_cp_active, all write enables, in_ready, out_valid, out_data, busy, job_done and all addresses; all counters SHALL clear.
REQ-020 After reset, the first rising clock edge with reset=0 SHALL be able to accept start.

Verification
REQ-021 Basic job: imem_len=3, dmem_len=2, res_base=5, res_len=2, with a stub that pulses cp_ext_done 10 cycles after ext_cp_active. Required: IMEM writes to addresses 0,1,2; DMEM writes to addresses 0,1; two reads at 5,6 appear on out_data in order; exactly one job_done.
REQ-022 Backpressure: hold out_ready=0 for 7 cycles in RD_OUT. Required: out_valid stays 1 and out_data is unchanged; there is no DMEM address change.
REQ-023 Zero lengths: imem_len=dmem_len=res_len=0. Required: start leads to RUN on the next cycle; after cp_ext_done, FIN, then job_done; in_ready is never 1.
REQ-024 Wrap: res_base=1022, res_len=4. Required: read addresses 1022, 1023, 0, 1.
REQ-025 Reset mid-RUN: assert reset while ext_cp_active=1. Required: ext_cp_active=0 and busy=0 asynchronously, and the next start is accepted normally.
REQ-026 Stall and ignored start: toggle in_valid randomly and pulse start during LOAD_D. Required: the write count equals dmem_len exactly, and the second start has no effect.
